// File: rtl/ball_motion_if.sv
// ball_motion_if
//   Bundles the frame/collision inputs and the ball position outputs of
//   ball_motion so the collision checker side and the ball side share one
//   connection object.
//
//   Handshake: there is no valid/ready pair. Inputs are sampled on every
//   pxl_clk edge. Outputs are registered. The position outputs change only
//   on the edge that samples a frame tick (the first vsync=1 cycle), on a
//   start cycle, or on reset. Consumers may read them at any time during
//   active scan (vsync=0).
//
//   slave  : view used by ball_motion (inputs in, position/state out)
//   master : view used by the driving side (collision checker / bench)
interface ball_motion_if;
    logic       vsync;
    logic       start;
    logic       launch;
    logic [9:0] paddle_x;
    logic       h_collision;
    logic       v_collision;
    logic       win;
    logic       lose;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       in_play;
    logic [1:0] dbg_state;   // FSM state: 0 SERVE, 1 PLAY, 2 OVER

    modport slave (
        input  vsync, start, launch, paddle_x, h_collision, v_collision, win, lose,
        output ball_x, ball_y, dir_x, dir_y, in_play, dbg_state
    );

    modport master (
        output vsync, start, launch, paddle_x, h_collision, v_collision, win, lose,
        input  ball_x, ball_y, dir_x, dir_y, in_play, dbg_state
    );
endinterface

// File: rtl/ball_motion.sv
// ball_motion
//   Once per video frame, advances the ball position that the collision
//   checker consumes. The ball bounces on the collision flags latched during
//   active scan and on the left, right and top playfield walls. A three-state
//   FSM (SERVE / PLAY / OVER) tracks the serve, play and game-over phases.
//
//   Ports
//     pxl_clk : pixel clock, the only clock
//     reset   : synchronous, active-high
//     bus     : ball_motion_if.slave (frame/collision inputs, position outputs,
//               debug FSM state)
module ball_motion #(
    parameter logic [3:0] SPEED      = 4'd2,
    parameter logic [9:0] LEFT_EDGE  = 10'd8,
    parameter logic [9:0] RIGHT_EDGE = 10'd631,
    parameter logic [9:0] TOP_EDGE   = 10'd8,
    parameter logic [9:0] SERVE_X    = 10'd320,
    parameter logic [9:0] SERVE_Y    = 10'd440
) (
    input  logic         pxl_clk,
    input  logic         reset,
    ball_motion_if.slave bus
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [10:0] L_SPEED = {7'd0, SPEED};

    state_t     r_state;
    state_t     w_state_next;
    logic       r_vsync_q;
    logic       r_h_hit;
    logic       r_v_hit;
    logic [9:0] r_ball_x;
    logic [9:0] r_ball_y;
    logic       r_dir_x;
    logic       r_dir_y;
    logic       r_in_play;

    logic        w_tick;
    logic        w_ndx;
    logic        w_ndy;
    logic [10:0] w_x_up;
    logic [10:0] w_y_up;
    logic [9:0]  w_serve_x;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic        w_dx_next;
    logic        w_dy_next;

    assign w_tick = bus.vsync & ~r_vsync_q;

    // Next-state logic; start overrides everything except reset.
    always_comb begin
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = SERVE;
        end else begin
            case (r_state)
                SERVE:   if (w_tick && bus.launch) w_state_next = PLAY;
                PLAY:    if (bus.win || bus.lose)  w_state_next = OVER;
                OVER:    w_state_next = OVER;
                default: w_state_next = SERVE;
            endcase
        end
    end

    // Per-frame step. Sums are 11 bits wide so edge compares never wrap.
    always_comb begin
        w_ndx  = r_dir_x ^ r_h_hit;
        w_ndy  = r_dir_y ^ r_v_hit;
        w_x_up = {1'b0, r_ball_x} + L_SPEED;
        w_y_up = {1'b0, r_ball_y} + L_SPEED;

        w_serve_x = bus.paddle_x;
        if (bus.paddle_x < LEFT_EDGE)  w_serve_x = LEFT_EDGE;
        if (bus.paddle_x > RIGHT_EDGE) w_serve_x = RIGHT_EDGE;

        w_x_next  = r_ball_x;
        w_dx_next = w_ndx;
        if (w_ndx && (w_x_up >= {1'b0, RIGHT_EDGE})) begin
            w_x_next  = RIGHT_EDGE;
            w_dx_next = 1'b0;
        end else if (!w_ndx && ({1'b0, r_ball_x} <= ({1'b0, LEFT_EDGE} + L_SPEED))) begin
            w_x_next  = LEFT_EDGE;
            w_dx_next = 1'b1;
        end else if (w_ndx) begin
            w_x_next  = w_x_up[9:0];
        end else begin
            w_x_next  = r_ball_x - {6'd0, SPEED};
        end

        // No bottom bounce: losing the ball is signalled by the checker.
        w_y_next  = r_ball_y;
        w_dy_next = w_ndy;
        if (!w_ndy && ({1'b0, r_ball_y} <= ({1'b0, TOP_EDGE} + L_SPEED))) begin
            w_y_next  = TOP_EDGE;
            w_dy_next = 1'b1;
        end else if (w_ndy) begin
            w_y_next  = w_y_up[10] ? 10'd1023 : w_y_up[9:0];
        end else begin
            w_y_next  = r_ball_y - {6'd0, SPEED};
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            r_state   <= SERVE;
            r_vsync_q <= 1'b0;
            r_h_hit   <= 1'b0;
            r_v_hit   <= 1'b0;
            r_ball_x  <= SERVE_X;
            r_ball_y  <= SERVE_Y;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b0;
            r_in_play <= 1'b0;
        end else begin
            r_vsync_q <= bus.vsync;
            r_state   <= w_state_next;
            r_in_play <= (w_state_next == PLAY);
            if (bus.start) begin
                r_dir_x  <= 1'b1;
                r_dir_y  <= 1'b0;
                r_ball_y <= SERVE_Y;
                r_h_hit  <= 1'b0;
                r_v_hit  <= 1'b0;
            end else begin
                case (r_state)
                    SERVE: begin
                        r_h_hit <= 1'b0;
                        r_v_hit <= 1'b0;
                        if (w_tick) begin
                            r_ball_x <= w_serve_x;
                            r_ball_y <= SERVE_Y;
                            if (bus.launch) begin
                                r_dir_x <= 1'b1;
                                r_dir_y <= 1'b0;
                            end
                        end
                    end
                    PLAY: begin
                        if (bus.win || bus.lose) begin
                            // Freeze position and direction on game end.
                            r_h_hit <= 1'b0;
                            r_v_hit <= 1'b0;
                        end else if (w_tick) begin
                            r_ball_x <= w_x_next;
                            r_ball_y <= w_y_next;
                            r_dir_x  <= w_dx_next;
                            r_dir_y  <= w_dy_next;
                            r_h_hit  <= 1'b0;
                            r_v_hit  <= 1'b0;
                        end else if (!bus.vsync) begin
                            // Sticky: several pulses in a frame are one hit.
                            r_h_hit <= r_h_hit | bus.h_collision;
                            r_v_hit <= r_v_hit | bus.v_collision;
                        end
                    end
                    default: begin
                        r_h_hit <= 1'b0;
                        r_v_hit <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ball_x    = r_ball_x;
    assign bus.ball_y    = r_ball_y;
    assign bus.dir_x     = r_dir_x;
    assign bus.dir_y     = r_dir_y;
    assign bus.in_play   = r_in_play;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;
  logic pxl_clk;
  logic reset;
  ball_motion_if bus();

  ball_motion dut (
    .pxl_clk (pxl_clk),
    .reset   (reset),
    .bus     (bus)
  );

  // clock / reset
  initial pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  // scoreboard: {x[9:0], y[9:0], dir_x, dir_y, in_play, state[1:0]}
  logic [24:0] exp_q[$];
  string       name_q[$];
  event        chk_ev;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic expect_out(input string nm, input int x, input int y,
                            input int dx, input int dy, input int ip, input int st);
    logic [24:0] e;
    e = {10'(x), 10'(y), 1'(dx), 1'(dy), 1'(ip), 2'(st)};
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> chk_ev;
    #1;
  endtask

  // monitor
  initial begin
    logic [24:0] e;
    logic [24:0] a;
    string       nm;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus.ball_x, bus.ball_y, bus.dir_x, bus.dir_y, bus.in_play, bus.dbg_state};
        n_checks++;
        if (a === e) n_pass++;
        else
          $display("FAIL %s: got x=%0d y=%0d dx=%0d dy=%0d ip=%0d st=%0d, want x=%0d y=%0d dx=%0d dy=%0d ip=%0d st=%0d",
                   nm, a[24:15], a[14:5], a[4], a[3], a[2], a[1:0],
                   e[24:15], e[14:5], e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  // driver: 6 active-scan cycles (collision pulses on even cycles), then
  // vsync rises; returns one cycle after the tick edge
  task automatic run_frame(input int nh, input int nv);
    for (int i = 0; i < 6; i++) begin
      @(negedge pxl_clk);
      bus.vsync       = 1'b0;
      bus.h_collision = ((i % 2) == 0) && ((i / 2) < nh);
      bus.v_collision = ((i % 2) == 0) && ((i / 2) < nv);
    end
    @(negedge pxl_clk);
    bus.vsync       = 1'b1;
    bus.h_collision = 1'b0;
    bus.v_collision = 1'b0;
    @(negedge pxl_clk);
  endtask

  task automatic run_frames(input int n, input int nh, input int nv);
    for (int i = 0; i < n; i++) run_frame(nh, nv);
  endtask

  // stimulus
  initial begin
    reset           = 1'b1;
    bus.vsync       = 1'b0;
    bus.start       = 1'b0;
    bus.launch      = 1'b0;
    bus.paddle_x    = 10'd100;
    bus.h_collision = 1'b0;
    bus.v_collision = 1'b0;
    bus.win         = 1'b0;
    bus.lose        = 1'b0;
    repeat (3) @(negedge pxl_clk);
    reset = 1'b0;
    expect_out("reset", 320, 440, 1, 0, 0, 0);

    for (int f = 0; f < 3; f++) begin
      run_frame(0, 0);
      expect_out("serve_follow", 100, 440, 1, 0, 0, 0);
    end

    bus.launch = 1'b1;
    run_frame(0, 0);
    bus.launch = 1'b0;
    expect_out("launch", 100, 440, 1, 0, 1, 1);
    run_frame(0, 0);
    expect_out("first_step", 102, 438, 1, 0, 1, 1);

    @(negedge pxl_clk);
    bus.start = 1'b1;
    @(negedge pxl_clk);
    bus.start = 1'b0;
    expect_out("start_from_play", 102, 440, 1, 0, 0, 0);

    bus.paddle_x = 10'd3;
    run_frame(0, 0);
    expect_out("clamp_left", 8, 440, 1, 0, 0, 0);
    bus.paddle_x = 10'd700;
    run_frame(0, 0);
    expect_out("clamp_right", 631, 440, 1, 0, 0, 0);

    bus.paddle_x = 10'd60;
    bus.launch   = 1'b1;
    run_frame(0, 0);
    bus.launch   = 1'b0;
    expect_out("launch2", 60, 440, 1, 0, 1, 1);
    run_frames(70, 0, 0);
    expect_out("reach_200_300", 200, 300, 1, 0, 1, 1);
    run_frame(0, 3);
    expect_out("multi_v_single_flip", 202, 302, 1, 1, 1, 1);

    run_frames(214, 0, 0);
    expect_out("near_right", 630, 730, 1, 1, 1, 1);
    run_frame(0, 0);
    expect_out("right_wall", 631, 732, 0, 1, 1, 1);
    run_frame(0, 0);
    expect_out("after_right", 629, 734, 0, 1, 1, 1);

    run_frames(145, 0, 0);
    expect_out("y_saturate", 339, 1023, 0, 1, 1, 1);
    run_frame(0, 1);
    expect_out("v_flip_up", 337, 1021, 0, 0, 1, 1);
    run_frames(342, 1, 0);
    expect_out("h_toggle", 337, 337, 0, 0, 1, 1);
    run_frames(164, 0, 0);
    expect_out("at_corner", 9, 9, 0, 0, 1, 1);
    run_frame(1, 0);
    expect_out("corner_bounce", 11, 8, 1, 1, 1, 1);

    @(negedge pxl_clk);
    bus.vsync = 1'b0;
    @(negedge pxl_clk);
    bus.lose = 1'b1;
    @(negedge pxl_clk);
    bus.lose = 1'b0;
    expect_out("lose_over", 11, 8, 1, 1, 0, 2);
    for (int f = 0; f < 5; f++) begin
      run_frame(1, 1);
      expect_out("over_frozen", 11, 8, 1, 1, 0, 2);
    end

    @(negedge pxl_clk);
    bus.start = 1'b1;
    bus.win   = 1'b1;
    @(negedge pxl_clk);
    bus.start = 1'b0;
    bus.win   = 1'b0;
    expect_out("start_beats_win", 11, 440, 1, 0, 0, 0);

    bus.paddle_x = 10'd200;
    run_frame(0, 0);
    expect_out("serve_again", 200, 440, 1, 0, 0, 0);
    @(negedge pxl_clk);
    bus.vsync = 1'b0;
    @(negedge pxl_clk);
    reset = 1'b1;
    @(negedge pxl_clk);
    reset = 1'b0;
    expect_out("reset_mid_frame", 320, 440, 1, 0, 0, 0);

    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball position generator for the brick-breaker datapath. Once per video frame it advances `ball_x`/`ball_y`, the coordinates consumed by the collision checker. It reverses direction on the `h_collision`/`v_collision` flags that checker produces, and on the playfield walls. A small state machine handles serve, play and game-over, and follows the checker's `start`, `win` and `lose` signals.

## Interface
- `SPEED`, 2: pixels moved per axis per frame (1..15)
- `LEFT_EDGE`, 8: minimum `ball_x`
- `RIGHT_EDGE`, 631: maximum `ball_x`
- `TOP_EDGE`, 8: minimum `ball_y`
- `SERVE_X`, 320: `ball_x` after reset
- `SERVE_Y`, 440: `ball_y` while serving (just above paddle)
- `pxl_clk` in 1: pixel clock, sole clock
- `reset` in 1: synchronous, active-high reset
- `vsync` in 1: frame sync; high = update window, low = active scan
- `start` in 1: new-game request (same signal the collision checker uses)
- `launch` in 1: serve request, level-sensitive
- `paddle_x` in 10: paddle centre column
- `h_collision` in 1: horizontal-face hit
- `v_collision` in 1: vertical-face hit
- `win` in 1: level, all blocks cleared
- `lose` in 1: level, ball past bottom edge
- `ball_x` out 10: ball centre column
- `ball_y` out 10: ball centre row
- `dir_x` out 1: 1 = moving right, 0 = left
- `dir_y` out 1: 1 = moving down, 0 = up
- `in_play` out 1: high only in state PLAY

## Operation
- States: SERVE, PLAY, OVER. Reset enters SERVE.
- Reset values: `ball_x`=`SERVE_X`, `ball_y`=`SERVE_Y`, `dir_x`=1, `dir_y`=0, `in_play`=0. Internal `vsync_q`=0, `h_hit`=0, `v_hit`=0.
- Frame tick: the cycle where `vsync`=1 and `vsync_q`=0. `vsync_q` is `vsync` registered every cycle.
- Hit latches:
  - While `vsync`=0 and state is PLAY, `h_hit` |= `h_collision` and `v_hit` |= `v_collision`.
  - Multiple pulses in one frame count as one hit.
  - Both latches clear on every tick and in every non-PLAY state.
- SERVE, on each tick:
  - `ball_x` <= `paddle_x`, clamped to [`LEFT_EDGE`,`RIGHT_EDGE`]; `ball_y` <= `SERVE_Y`.
  - If `launch`=1 on the tick: go to PLAY with `dir_x`=1, `dir_y`=0. Position this tick is still the serve position.
- PLAY, on each tick, evaluated in this order:
  1. New directions: `ndx` = `dir_x` ^ `h_hit`; `ndy` = `dir_y` ^ `v_hit`.
  2. X step:
     - `ndx`=1 and `ball_x`+`SPEED` >= `RIGHT_EDGE`: `ball_x` <= `RIGHT_EDGE`, `dir_x` <= 0.
     - `ndx`=0 and `ball_x` <= `LEFT_EDGE`+`SPEED`: `ball_x` <= `LEFT_EDGE`, `dir_x` <= 1.
     - Otherwise: `ball_x` += or -= `SPEED`, `dir_x` <= `ndx`.
  3. Y step:
     - `ndy`=0 and `ball_y` <= `TOP_EDGE`+`SPEED`: `ball_y` <= `TOP_EDGE`, `dir_y` <= 1.
     - `ndy`=1: `ball_y` += `SPEED`, saturating at 1023.
     - Otherwise: `ball_y` -= `SPEED`, `dir_y` <= `ndy`.
  - There is no bottom bounce; the bottom edge is the collision checker's `lose`.
- Arithmetic: edge compares use an 11-bit sum, so there is no 10-bit wrap.
- Leaving PLAY: `win` or `lose` high in any cycle → OVER. Position and direction freeze; latches clear.
- OVER holds until `start`.
- `start`, from any state: → SERVE, `dir_x`=1, `dir_y`=0, `ball_y`=`SERVE_Y`, latches clear. `start` takes priority over `win`/`lose`/`launch`/tick in the same cycle.
- `reset` takes priority over everything.

## Timing
- `ball_x`, `ball_y`, `dir_*` change only on the clock edge that samples the tick, plus a `start` cycle (`dir_*`, `ball_y`) and `reset`.
- Outputs are stable for all of the active scan the collision checker evaluates.
- Latency: a collision pulse in frame N affects the position at the tick ending frame N, visible from the next cycle.
- A collision pulse in the same cycle as a tick is ignored, since `vsync`=1 in that cycle.
- `in_play` is registered and updates on the edge of the state change.
- `reset` asserted mid-frame: all state returns to reset values on that edge; a pending hit is lost.

## Test plan
- Reset, `paddle_x`=100, three frames, no `launch` → `ball_x`=100, `ball_y`=440, `in_play`=0.
- Serve: `launch`=1 at tick → PLAY. Next tick: `ball_x`=102, `ball_y`=438.
- Three `v_collision` pulses in one frame at (200,300) moving up → next tick `dir_y`=1, `ball_y`=302 (single flip).
- Right wall: `ball_x`=630, `dir_x`=1 → tick → `ball_x`=631, `dir_x`=0. Next tick → 629.
- Corner: `ball_x`=9, `ball_y`=9, moving up-left, `h_hit` set → `dir_x`=1, `ball_x`=11; `ball_y`=8, `dir_y`=1.
- `lose`=1 mid-frame → OVER, position frozen across 5 ticks. `start` and `win` in the same cycle → SERVE. Then `reset` mid-frame → `ball_x`=320, `ball_y`=440.
